regfile_writeback_queue: RTL and testbench
==========================================

// Module: regfile_writeback_queue
// PURPOSE
//  Write-side companion of the 32x32 register file: buffers register write requests from
//  multi-cycle producers (load unit, multiplier) in a small FIFO.
//  Drains one entry per cycle into the register file's single write port (RegWrite /
//  WriteRegister / WriteData) whenever the main pipeline is not using that port.
//  Forwards the youngest pending value for both read addresses, so the datapath never
//  reads a stale register while a write is still queued.
// PARAMETERS
//  N      32  data width, equal to register file width
//  DEPTH   4  queue entries, power of two, >=2
//  PTR_W   2  log2(DEPTH)
// PORTS
//  clk                 in   1        rising-edge clock
//  reset               in   1        asynchronous, active-high reset
//  in_WrValid          in   1        producer presents a write request
//  o_WrReady           out  1        queue can accept (=!full)
//  in_WrRegister_5     in   5        destination register of request
//  in_WrData           in   N        data of request
//  in_PortBusy         in   1        main pipeline owns the regfile write port this cycle
//  o_RegWrite          out  1        write enable to register file
//  o_WriteRegister_5   out  5        register file write address (head entry)
//  o_WriteData         out  N        register file write data (head entry)
//  in_ReadRegister1_5  in   5        read address 1 (same as regfile port 1)
//  in_ReadRegister2_5  in   5        read address 2
//  o_Hit1 / o_Hit2     out  1        pending queued value exists for read addr 1 / 2
//  o_FwdData1/2        out  N        youngest pending value for addr 1 / 2, 0 when no hit
//  o_Count             out  PTR_W+1  number of occupied entries, 0..DEPTH
//  o_Empty             out  1        o_Count==0
// BEHAVIOUR
//  - Reset (async): rd/wr pointers, count, all entry valid/addr/data cleared.
//    Outputs: o_WrReady=1, o_Empty=1, o_Count=0, o_RegWrite=0, o_WriteRegister_5=0,
//    o_WriteData=0, hits=0, fwd data=0.
//  - Accept: push = in_WrValid & o_WrReady, sampled at rising edge.
//    Entry written at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
//  - Register 0: request with in_WrRegister_5==0 is handshaken (consumed) but NOT enqueued.
//    Count unchanged; no write ever issued to $zero.
//  - Drain: pop = !o_Empty & !in_PortBusy.
//    o_RegWrite = pop (combinational); o_WriteRegister_5/o_WriteData = head entry, 0 when
//    empty. Register file captures on the same edge; entry retires on that edge.
//    rd_ptr wraps.
//  - Latency: request accepted at edge k reaches register file at edge k+1 at the earliest
//    (queue empty, port free). Throughput 1 write/cycle.
//  - Simultaneous push+pop: count unchanged, both pointers advance.
//    Push when full is impossible: o_WrReady=0.
//    No full pass-through: a pop in the same cycle does not raise o_WrReady.
//  - Order: strict FIFO. Two queued writes to the same register land in request order.
//  - Forwarding (combinational): scan occupied entries; the youngest entry whose address
//    equals the read address wins.
//    The entry being popped this cycle still hits, because the regfile updates only at
//    the edge. Read address 0 never hits.
//    A request arriving in the same cycle is not forwarded until it is enqueued.
//  - in_PortBusy held high indefinitely: queue holds and fills. o_WrReady drops at
//    count==DEPTH; the producer must stall.
//  - Reset asserted mid-operation: all pending writes are discarded immediately and
//    outputs return to reset values.
// TESTING
//  1. Reset, push r8=0x0000_00AA with port free -> next cycle o_RegWrite=1,
//     o_WriteRegister_5=8, o_WriteData=0xAA; then o_Empty=1.
//  2. in_PortBusy=1, push r9=1,r10=2,r11=3,r12=4 -> o_Count=4, o_WrReady=0.
//     Release busy -> writes r9..r12 on 4 consecutive cycles in order.
//  3. Busy, push r16=0x11 then r16=0x22; read addr1=16 -> o_Hit1=1, o_FwdData1=0x22.
//     Drain -> r16 written 0x11 then 0x22.
//     Hit persists until second retires, then o_Hit1=0, o_FwdData1=0.
//  4. Push r0=0xFFFF_FFFF -> handshake occurs, o_Count stays 0, o_RegWrite never 1.
//     Read addr 0 -> o_Hit=0.
//  5. Queue at 2 with busy=0, push each cycle for 8 cycles -> count stays 2.
//     Both pointers wrap cleanly and all 8 writes emerge in order with correct data.
//  6. Fill 3 entries, assert reset between edges -> o_Count=0, o_RegWrite=0 immediately.
//     None of the 3 writes is ever issued.

Source files
------------

// File: rtl/regfile_writeback_queue_if.sv
// Bundle of the signals between the register write queue and the rest of the datapath.
// Groups three sides:
//   - producer write request (in_WrValid / o_WrReady / in_WrRegister_5 / in_WrData)
//   - register file write port (in_PortBusy / o_RegWrite / o_WriteRegister_5 / o_WriteData)
//   - read-address forwarding (in_ReadRegister1/2_5 / o_Hit1/2 / o_FwdData1/2)
// Queue status is also carried here (o_Count / o_Empty).
// Modports:
//   master : the surrounding datapath, which drives requests and read addresses.
//   slave  : the queue itself.
interface regfile_writeback_queue_if #(
    parameter int N     = 32,
    parameter int PTR_W = 2
);
    logic             in_WrValid;
    logic             o_WrReady;
    logic [4:0]       in_WrRegister_5;
    logic [N-1:0]     in_WrData;
    logic             in_PortBusy;
    logic             o_RegWrite;
    logic [4:0]       o_WriteRegister_5;
    logic [N-1:0]     o_WriteData;
    logic [4:0]       in_ReadRegister1_5;
    logic [4:0]       in_ReadRegister2_5;
    logic             o_Hit1;
    logic             o_Hit2;
    logic [N-1:0]     o_FwdData1;
    logic [N-1:0]     o_FwdData2;
    logic [PTR_W:0]   o_Count;
    logic             o_Empty;

    modport master (
        output in_WrValid, in_WrRegister_5, in_WrData, in_PortBusy,
               in_ReadRegister1_5, in_ReadRegister2_5,
        input  o_WrReady, o_RegWrite, o_WriteRegister_5, o_WriteData,
               o_Hit1, o_Hit2, o_FwdData1, o_FwdData2, o_Count, o_Empty
    );

    modport slave (
        input  in_WrValid, in_WrRegister_5, in_WrData, in_PortBusy,
               in_ReadRegister1_5, in_ReadRegister2_5,
        output o_WrReady, o_RegWrite, o_WriteRegister_5, o_WriteData,
               o_Hit1, o_Hit2, o_FwdData1, o_FwdData2, o_Count, o_Empty
    );
endinterface

// File: rtl/regfile_writeback_queue.sv
// Write-side companion of the 32x32 register file.
// Buffers register write requests from multi-cycle producers in a small FIFO and drains
// one entry per cycle into the register file's single write port whenever the main
// pipeline is not using it. Both read addresses are forwarded from the youngest queued
// value, so the datapath never observes a stale register while a write is pending.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset; discards all pending writes
//   bus   : slave side of regfile_writeback_queue_if (request, write port, forwarding,
//           status)
module regfile_writeback_queue #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    regfile_writeback_queue_if.slave bus
);

    logic [DEPTH-1:0]  valid_r;
    logic [4:0]        addr_r [DEPTH];
    logic [N-1:0]      data_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    count_r;

    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic              hit1_s;
    logic              hit2_s;
    logic [N-1:0]      fwd1_s;
    logic [N-1:0]      fwd2_s;

    // Handshake, drain and status decode.
    always_comb begin
        full_s  = (count_r == (PTR_W+1)'(DEPTH));
        empty_s = (count_r == '0);
        // A request to $zero is consumed by the handshake but never stored.
        push_s  = bus.in_WrValid && !full_s && (bus.in_WrRegister_5 != 5'd0);
        pop_s   = !empty_s && !bus.in_PortBusy;
    end

    // Forwarding scan from oldest to youngest so the youngest matching entry wins.
    // An entry being popped this cycle still hits: the regfile only updates at the edge.
    always_comb begin
        hit1_s = 1'b0;
        hit2_s = 1'b0;
        fwd1_s = '0;
        fwd2_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] idx;
            idx = rd_ptr_r + PTR_W'(i);
            if (valid_r[idx] && (addr_r[idx] == bus.in_ReadRegister1_5)
                && (bus.in_ReadRegister1_5 != 5'd0)) begin
                hit1_s = 1'b1;
                fwd1_s = data_r[idx];
            end else begin
                hit1_s = hit1_s;
            end
            if (valid_r[idx] && (addr_r[idx] == bus.in_ReadRegister2_5)
                && (bus.in_ReadRegister2_5 != 5'd0)) begin
                hit2_s = 1'b1;
                fwd2_s = data_r[idx];
            end else begin
                hit2_s = hit2_s;
            end
        end
    end

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r  <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= 5'd0;
                data_r[i] <= '0;
            end
        end else begin
            // Retire first so a simultaneous push into the same slot (full wrap) wins;
            // that cannot happen while full blocks pushes, but the ordering stays safe.
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (push_s) begin
                valid_r[wr_ptr_r] <= 1'b1;
                addr_r[wr_ptr_r]  <= bus.in_WrRegister_5;
                data_r[wr_ptr_r]  <= bus.in_WrData;
                wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Output drive; the write port shows the head entry and zeros when empty.
    always_comb begin
        bus.o_WrReady  = !full_s;
        bus.o_Empty    = empty_s;
        bus.o_Count    = count_r;
        bus.o_RegWrite = pop_s;
        if (empty_s) begin
            bus.o_WriteRegister_5 = 5'd0;
            bus.o_WriteData       = '0;
        end else begin
            bus.o_WriteRegister_5 = addr_r[rd_ptr_r];
            bus.o_WriteData       = data_r[rd_ptr_r];
        end
        bus.o_Hit1     = hit1_s;
        bus.o_Hit2     = hit2_s;
        bus.o_FwdData1 = fwd1_s;
        bus.o_FwdData2 = fwd2_s;
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: reset, single write latency, fill/drain
// order, same-register forwarding, $zero filtering, steady push+pop with pointer wrap,
// and asynchronous reset discarding pending writes.
module tb_regfile_writeback_queue;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    regfile_writeback_queue_if #(.N(32), .PTR_W(2)) bus ();

    regfile_writeback_queue #(.N(32), .DEPTH(4), .PTR_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0]  exp_reg [10];
        logic [31:0] exp_dat [10];
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        bus.in_WrValid         = 1'b0;
        bus.in_WrRegister_5    = 5'd0;
        bus.in_WrData          = 32'd0;
        bus.in_PortBusy        = 1'b0;
        bus.in_ReadRegister1_5 = 5'd0;
        bus.in_ReadRegister2_5 = 5'd0;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        // Reset state
        chk("rst_ready",  {31'd0, bus.o_WrReady}, 32'd1);
        chk("rst_empty",  {31'd0, bus.o_Empty}, 32'd1);
        chk("rst_count",  {29'd0, bus.o_Count}, 32'd0);
        chk("rst_regwr",  {31'd0, bus.o_RegWrite}, 32'd0);
        chk("rst_wreg",   {27'd0, bus.o_WriteRegister_5}, 32'd0);
        chk("rst_wdata",  bus.o_WriteData, 32'd0);
        chk("rst_hit1",   {31'd0, bus.o_Hit1}, 32'd0);
        chk("rst_fwd1",   bus.o_FwdData1, 32'd0);

        // 1: single write, latency one edge
        cyc();
        bus.in_WrValid = 1'b1; bus.in_WrRegister_5 = 5'd8; bus.in_WrData = 32'h0000_00AA;
        bus.in_ReadRegister1_5 = 5'd8;
        #1;
        chk("t1_noearly_wr",  {31'd0, bus.o_RegWrite}, 32'd0);
        chk("t1_noearly_hit", {31'd0, bus.o_Hit1}, 32'd0);
        cyc();
        bus.in_WrValid = 1'b0;
        #1;
        chk("t1_regwr", {31'd0, bus.o_RegWrite}, 32'd1);
        chk("t1_wreg",  {27'd0, bus.o_WriteRegister_5}, 32'd8);
        chk("t1_wdata", bus.o_WriteData, 32'h0000_00AA);
        chk("t1_hit_popping", {31'd0, bus.o_Hit1}, 32'd1);
        chk("t1_fwd_popping", bus.o_FwdData1, 32'h0000_00AA);
        cyc();
        chk("t1_empty_after", {31'd0, bus.o_Empty}, 32'd1);
        chk("t1_regwr_after", {31'd0, bus.o_RegWrite}, 32'd0);

        // 2: fill under busy, then drain in order
        bus.in_PortBusy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_WrValid = 1'b1;
            bus.in_WrRegister_5 = 5'(9 + i);
            bus.in_WrData = 32'(i + 1);
            cyc();
        end
        bus.in_WrRegister_5 = 5'd13; bus.in_WrData = 32'h0000_0DDD;
        #1;
        chk("t2_count_full", {29'd0, bus.o_Count}, 32'd4);
        chk("t2_ready_low",  {31'd0, bus.o_WrReady}, 32'd0);
        chk("t2_busy_nowr",  {31'd0, bus.o_RegWrite}, 32'd0);
        cyc();
        chk("t2_full_hold",  {29'd0, bus.o_Count}, 32'd4);
        bus.in_WrValid = 1'b0;
        bus.in_PortBusy = 1'b0;
        #1;
        // Pop in the same cycle must not reopen the queue.
        chk("t2_no_passthru", {31'd0, bus.o_WrReady}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_regwr%0d", i), {31'd0, bus.o_RegWrite}, 32'd1);
            chk($sformatf("t2_wreg%0d", i),  {27'd0, bus.o_WriteRegister_5}, 32'(9 + i));
            chk($sformatf("t2_wdata%0d", i), bus.o_WriteData, 32'(i + 1));
            cyc();
        end
        chk("t2_empty", {31'd0, bus.o_Empty}, 32'd1);

        // 3: two writes to r16, youngest forwarded
        bus.in_PortBusy = 1'b1;
        bus.in_WrValid = 1'b1; bus.in_WrRegister_5 = 5'd16; bus.in_WrData = 32'h11;
        cyc();
        bus.in_WrData = 32'h22;
        cyc();
        bus.in_WrValid = 1'b0;
        bus.in_ReadRegister1_5 = 5'd16;
        bus.in_ReadRegister2_5 = 5'd16;
        #1;
        chk("t3_hit1", {31'd0, bus.o_Hit1}, 32'd1);
        chk("t3_fwd1", bus.o_FwdData1, 32'h22);
        chk("t3_hit2", {31'd0, bus.o_Hit2}, 32'd1);
        chk("t3_fwd2", bus.o_FwdData2, 32'h22);
        bus.in_ReadRegister2_5 = 5'd17;
        bus.in_PortBusy = 1'b0;
        #1;
        chk("t3_miss2",   {31'd0, bus.o_Hit2}, 32'd0);
        chk("t3_wdata_a", bus.o_WriteData, 32'h11);
        chk("t3_wreg_a",  {27'd0, bus.o_WriteRegister_5}, 32'd16);
        chk("t3_fwd_a",   bus.o_FwdData1, 32'h22);
        cyc();
        chk("t3_wdata_b", bus.o_WriteData, 32'h22);
        chk("t3_hit_b",   {31'd0, bus.o_Hit1}, 32'd1);
        chk("t3_fwd_b",   bus.o_FwdData1, 32'h22);
        cyc();
        chk("t3_hit_gone", {31'd0, bus.o_Hit1}, 32'd0);
        chk("t3_fwd_gone", bus.o_FwdData1, 32'd0);

        // 4: write to $zero is consumed, never queued
        bus.in_WrValid = 1'b1; bus.in_WrRegister_5 = 5'd0; bus.in_WrData = 32'hFFFF_FFFF;
        bus.in_ReadRegister1_5 = 5'd0;
        #1;
        chk("t4_ready", {31'd0, bus.o_WrReady}, 32'd1);
        cyc();
        bus.in_WrValid = 1'b0;
        #1;
        chk("t4_count", {29'd0, bus.o_Count}, 32'd0);
        chk("t4_regwr", {31'd0, bus.o_RegWrite}, 32'd0);
        chk("t4_hit0",  {31'd0, bus.o_Hit1}, 32'd0);
        cyc();
        chk("t4_regwr2", {31'd0, bus.o_RegWrite}, 32'd0);

        // 5: steady state at two entries with push and pop every cycle
        exp_reg[0] = 5'd1; exp_dat[0] = 32'h100;
        exp_reg[1] = 5'd2; exp_dat[1] = 32'h101;
        for (int i = 0; i < 8; i++) begin
            exp_reg[i + 2] = 5'(3 + i);
            exp_dat[i + 2] = 32'h200 + 32'(i);
        end
        bus.in_PortBusy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.in_WrValid = 1'b1;
            bus.in_WrRegister_5 = exp_reg[i];
            bus.in_WrData = exp_dat[i];
            cyc();
        end
        bus.in_PortBusy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.in_WrValid = 1'b1;
            bus.in_WrRegister_5 = exp_reg[i + 2];
            bus.in_WrData = exp_dat[i + 2];
            #1;
            chk($sformatf("t5_count%0d", i), {29'd0, bus.o_Count}, 32'd2);
            chk($sformatf("t5_wreg%0d", i),  {27'd0, bus.o_WriteRegister_5}, 32'(exp_reg[i]));
            chk($sformatf("t5_wdata%0d", i), bus.o_WriteData, exp_dat[i]);
            cyc();
        end
        bus.in_WrValid = 1'b0;
        for (int i = 8; i < 10; i++) begin
            #1;
            chk($sformatf("t5_tail_wreg%0d", i),  {27'd0, bus.o_WriteRegister_5}, 32'(exp_reg[i]));
            chk($sformatf("t5_tail_wdata%0d", i), bus.o_WriteData, exp_dat[i]);
            cyc();
        end
        chk("t5_empty", {31'd0, bus.o_Empty}, 32'd1);

        // 6: reset mid-operation discards pending writes
        bus.in_PortBusy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_WrValid = 1'b1;
            bus.in_WrRegister_5 = 5'(20 + i);
            bus.in_WrData = 32'h300 + 32'(i);
            cyc();
        end
        bus.in_WrValid = 1'b0;
        bus.in_ReadRegister1_5 = 5'd20;
        #1;
        chk("t6_count3", {29'd0, bus.o_Count}, 32'd3);
        #1;
        bus.in_PortBusy = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_rst_count", {29'd0, bus.o_Count}, 32'd0);
        chk("t6_rst_regwr", {31'd0, bus.o_RegWrite}, 32'd0);
        chk("t6_rst_hit",   {31'd0, bus.o_Hit1}, 32'd0);
        chk("t6_rst_wreg",  {27'd0, bus.o_WriteRegister_5}, 32'd0);
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("t6_never_wr%0d", i), {31'd0, bus.o_RegWrite}, 32'd0);
        end
        chk("t6_empty", {31'd0, bus.o_Empty}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
